// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared match-state encodings and widths for the pong engine, overlay and sequencer
// Contents:
//   state_t    : match FSM encoding (values are visible to the overlay through STATE)
//   LIVES_W    : width of the lives counter
//   LEVEL_W    : width of the speed level
//   LEVEL_MAX  : highest speed level
//   cnt_width  : width needed for a frame countdown holding either of two frame counts
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_MISS_PAUSE = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 2;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd3;

  // A count of 0 is promoted to 1 at load time, so the counter must hold at least 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pong_match_ctrl_frame_countdown.sv
// rtl/pong_match_ctrl_frame_countdown.sv - loadable frame down-counter shared by serve wait and miss pause
// Ports:
//   VGA_CLOCK  in  : pixel clock, posedge
//   RESET      in  : asynchronous, active-high
//   load       in  : load load_val (takes priority over tick)
//   load_val   in  : frames to count; 0 is treated as 1
//   tick       in  : one-cycle frame pulse
//   expire     out : high in the cycle a tick arrives while the count is 1
module frame_countdown
  import pong_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             VGA_CLOCK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Not gated by load: the owner reloads in the same cycle it consumes expire,
  // and gating here would make load depend on itself.
  assign expire = tick && (count == CNT_W'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: serve/play/miss/game-over flow, lives, score, speed level
// Optional feature macro: PONG_HIGH_SCORE_EN (keeps a best-score register; otherwise HIGH_SCORE is 0)
// Ports:
//   VGA_CLOCK    in  : pixel clock, posedge
//   RESET        in  : asynchronous, active-high
//   START        in  : debounced start button level
//   FRAME_TICK   in  : one-cycle pulse per frame
//   BALL_HIT     in  : one-cycle pulse, paddle reflected the ball
//   BALL_MISSED  in  : one-cycle pulse, ball passed the paddle
//   BALL_ENABLE  out : ball may move
//   SERVE        out : one-cycle pulse, engine recentres and serves the ball
//   SCORE        out : paddle hits this match (saturating)
//   LIVES        out : remaining lives
//   SPEED_LEVEL  out : 0..3 ball speed level
//   STATE        out : match state encoding (pong_pkg::state_t)
//   HIGH_SCORE   out : best score since reset
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 90,
  parameter int HITS_PER_LEVEL = 8,
  parameter int SCORE_W        = 8
) (
  input  logic               VGA_CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic               FRAME_TICK,
  input  logic               BALL_HIT,
  input  logic               BALL_MISSED,
  output logic               BALL_ENABLE,
  output logic               SERVE,
  output logic [SCORE_W-1:0] SCORE,
  output logic [1:0]         LIVES,
  output logic [1:0]         SPEED_LEVEL,
  output logic [2:0]         STATE,
  output logic [SCORE_W-1:0] HIGH_SCORE
);

  localparam int CNT_W = cnt_width(SERVE_FRAMES, MISS_FRAMES);
  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [CNT_W-1:0]   SERVE_VAL = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   MISS_VAL  = CNT_W'(MISS_FRAMES);
  localparam logic [HIT_W-1:0]   HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [LIVES_W-1:0] LIVES_LD  = LIVES_W'(LIVES_INIT);

  state_t           state;
  logic             start_q;
  logic             start_evt;
  logic [HIT_W-1:0] hit_cnt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             expire;

  assign start_evt = START & ~start_q;
  assign STATE     = state;

  // Every entry into a counting state loads the shared countdown in the same
  // cycle as the transition, so a coincident frame tick is swallowed by the load.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = SERVE_VAL;
    case (state)
      ST_IDLE, ST_GAME_OVER: cnt_load = start_evt;
      ST_PLAY: begin
        if (BALL_MISSED && (LIVES > 2'd1)) begin
          cnt_load = 1'b1;
          cnt_val  = MISS_VAL;
        end
      end
      ST_MISS_PAUSE: cnt_load = expire;
      default: cnt_load = 1'b0;
    endcase
  end

  frame_countdown #(
    .CNT_W(CNT_W)
  ) u_countdown (
    .VGA_CLOCK(VGA_CLOCK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (FRAME_TICK),
    .expire   (expire)
  );

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      BALL_ENABLE <= 1'b0;
      SERVE       <= 1'b0;
      SCORE       <= '0;
      LIVES       <= '0;
      SPEED_LEVEL <= '0;
      hit_cnt     <= '0;
    end else begin
      start_q     <= START;
      SERVE       <= 1'b0;
      BALL_ENABLE <= 1'b0;
      case (state)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_evt) begin
            state       <= ST_SERVE_WAIT;
            LIVES       <= LIVES_LD;
            SCORE       <= '0;
            SPEED_LEVEL <= '0;
            hit_cnt     <= '0;
          end
        end
        ST_SERVE_WAIT: begin
          if (expire) begin
            state <= ST_PLAY;
            SERVE <= 1'b1;
          end
        end
        ST_PLAY: begin
          // A miss discards any hit reported in the same cycle.
          if (BALL_MISSED) begin
            LIVES <= (LIVES == '0) ? '0 : LIVES - 2'd1;
            state <= (LIVES <= 2'd1) ? ST_GAME_OVER : ST_MISS_PAUSE;
          end else begin
            BALL_ENABLE <= 1'b1;
            if (BALL_HIT) begin
              if (SCORE != '1) SCORE <= SCORE + 1'b1;
              if (hit_cnt >= HIT_LAST) begin
                hit_cnt <= '0;
                if (SPEED_LEVEL != LEVEL_MAX) SPEED_LEVEL <= SPEED_LEVEL + 2'd1;
              end else begin
                hit_cnt <= hit_cnt + 1'b1;
              end
            end
          end
        end
        ST_MISS_PAUSE: begin
          if (expire) begin
            state   <= ST_SERVE_WAIT;
            hit_cnt <= '0;
            if (SPEED_LEVEL != '0) SPEED_LEVEL <= SPEED_LEVEL - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PONG_HIGH_SCORE_EN
  // Captured on the miss that ends the match; SCORE is stable in that cycle.
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      HIGH_SCORE <= '0;
    end else if ((state == ST_PLAY) && BALL_MISSED && (LIVES <= 2'd1) && (SCORE > HIGH_SCORE)) begin
      HIGH_SCORE <= SCORE;
    end
  end
`else
  assign HIGH_SCORE = '0;
`endif

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;
  import pong_pkg::*;

  logic       VGA_CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       FRAME_TICK = 1'b0;
  logic       BALL_HIT = 1'b0;
  logic       BALL_MISSED = 1'b0;
  logic       BALL_ENABLE;
  logic       SERVE;
  logic [7:0] SCORE;
  logic [1:0] LIVES;
  logic [1:0] SPEED_LEVEL;
  logic [2:0] STATE;
  logic [7:0] HIGH_SCORE;

  int checks = 0;
  int errors = 0;
  int hs_exp;

  typedef struct {
    logic hit, miss, tick, start;
    int   score, lives, level, state, en, serve;
  } vec_t;

  vec_t tbl [12];

  pong_match_ctrl dut (
    .VGA_CLOCK  (VGA_CLOCK),
    .RESET      (RESET),
    .START      (START),
    .FRAME_TICK (FRAME_TICK),
    .BALL_HIT   (BALL_HIT),
    .BALL_MISSED(BALL_MISSED),
    .BALL_ENABLE(BALL_ENABLE),
    .SERVE      (SERVE),
    .SCORE      (SCORE),
    .LIVES      (LIVES),
    .SPEED_LEVEL(SPEED_LEVEL),
    .STATE      (STATE),
    .HIGH_SCORE (HIGH_SCORE)
  );

  always #5 VGA_CLOCK = ~VGA_CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge VGA_CLOCK);
    #1;
  endtask

  task automatic chk_all(input string tag, input int score, input int lives, input int level,
                         input int st, input int en, input int srv);
    chk({tag, ".score"}, 32'(SCORE), score);
    chk({tag, ".lives"}, 32'(LIVES), lives);
    chk({tag, ".level"}, 32'(SPEED_LEVEL), level);
    chk({tag, ".state"}, 32'(STATE), st);
    chk({tag, ".ball_enable"}, 32'(BALL_ENABLE), en);
    chk({tag, ".serve"}, 32'(SERVE), srv);
  endtask

  // 60 frame ticks spaced 10 cycles apart; SERVE must fire once, on the last tick.
  task automatic do_serve(input string tag);
    int sc = 0;
    int at = 0;
    for (int t = 1; t <= 60; t++) begin
      FRAME_TICK = 1'b1;
      step();
      FRAME_TICK = 1'b0;
      if (SERVE) begin
        sc++;
        at = t;
      end
      if (t == 60) begin
        chk({tag, ".state_at_serve"}, 32'(STATE), 32'(ST_PLAY));
        chk({tag, ".en_at_serve"}, 32'(BALL_ENABLE), 0);
      end
      for (int k = 0; k < 9; k++) begin
        step();
        if (SERVE) sc++;
        if (t == 60 && k == 0) chk({tag, ".en_after_serve"}, 32'(BALL_ENABLE), 1);
      end
    end
    chk({tag, ".serve_count"}, sc, 1);
    chk({tag, ".serve_tick"}, at, 60);
  endtask

  task automatic do_pause(input string tag, input int n, input int exp_level);
    int first_sw = 0;
    for (int t = 1; t <= n; t++) begin
      FRAME_TICK = 1'b1;
      step();
      FRAME_TICK = 1'b0;
      if (STATE == 3'(ST_SERVE_WAIT) && first_sw == 0) first_sw = t;
      step();
      step();
    end
    chk({tag, ".expiry_tick"}, first_sw, n);
    chk({tag, ".level"}, 32'(SPEED_LEVEL), exp_level);
  endtask

  initial begin
    logic [2:0] bad_state;

`ifdef PONG_HIGH_SCORE_EN
    hs_exp = 62;
`else
    hs_exp = 0;
`endif

    //            hit miss tick start score lives lvl state en serve
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 3, 0, 2, 1, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 3, 0, 2, 1, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 0, 2, 1, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 3, 0, 2, 1, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 3, 0, 2, 1, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 3, 0, 2, 1, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 3, 0, 2, 1, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5, 3, 0, 2, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5, 2, 0, 3, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5, 2, 0, 3, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 5, 2, 0, 3, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 5, 2, 0, 3, 0, 0};

    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.high_score", 32'(HIGH_SCORE), 0);
    step();
    RESET = 1'b0;
    step();
    step();
    chk("idle.state", 32'(STATE), 32'(ST_IDLE));

    // Start with a coincident frame tick: the load must win
    START = 1'b1;
    FRAME_TICK = 1'b1;
    step();
    START = 1'b0;
    FRAME_TICK = 1'b0;
    chk_all("start1", 0, 3, 0, 1, 0, 0);
    do_serve("serve1");

    // Single-cycle vectors in PLAY, ending in a hit+miss collision and ignored events
    foreach (tbl[i]) begin
      BALL_HIT    = tbl[i].hit;
      BALL_MISSED = tbl[i].miss;
      FRAME_TICK  = tbl[i].tick;
      START       = tbl[i].start;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].score, tbl[i].lives, tbl[i].level,
              tbl[i].state, tbl[i].en, tbl[i].serve);
    end
    BALL_HIT = 1'b0;
    BALL_MISSED = 1'b0;
    FRAME_TICK = 1'b0;
    START = 1'b0;

    // One pause tick already consumed by the last vector
    do_pause("pause1", 89, 0);
    do_serve("serve2");

    // Level increments every 8 hits and saturates at 3
    BALL_HIT = 1'b1;
    for (int i = 0; i < 17; i++) step();
    BALL_HIT = 1'b0;
    step();
    chk("hits17.score", 32'(SCORE), 22);
    chk("hits17.level", 32'(SPEED_LEVEL), 2);
    BALL_HIT = 1'b1;
    for (int i = 0; i < 40; i++) step();
    BALL_HIT = 1'b0;
    step();
    chk("hits57.score", 32'(SCORE), 62);
    chk("hits57.level", 32'(SPEED_LEVEL), 3);

    // Second miss, pause expiry drops the level
    BALL_MISSED = 1'b1;
    step();
    BALL_MISSED = 1'b0;
    chk_all("miss2", 62, 1, 3, 3, 0, 0);
    do_pause("pause2", 90, 2);
    do_serve("serve3");

    // Last miss ends the match
    BALL_MISSED = 1'b1;
    step();
    BALL_MISSED = 1'b0;
    chk_all("gameover", 62, 0, 2, 4, 0, 0);
    step();
    chk("gameover.high_score", 32'(HIGH_SCORE), hs_exp);
    BALL_HIT = 1'b1;
    step();
    BALL_HIT = 1'b0;
    step();
    chk("gameover.hit_ignored", 32'(SCORE), 62);

    // Held START restarts exactly once; a retrigger would reload the countdown
    START = 1'b1;
    step();
    chk_all("restart", 0, 3, 0, 1, 0, 0);
    chk("restart.high_score", 32'(HIGH_SCORE), hs_exp);
    do_serve("serve4");
    START = 1'b0;

    // Asynchronous reset mid-play
    BALL_HIT = 1'b1;
    for (int i = 0; i < 9; i++) step();
    BALL_HIT = 1'b0;
    step();
    chk("pre_reset.score", 32'(SCORE), 9);
    #2;
    RESET = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    chk("async_reset.high_score", 32'(HIGH_SCORE), 0);
    step();
    step();
    RESET = 1'b0;
    BALL_HIT = 1'b1;
    for (int i = 0; i < 3; i++) step();
    BALL_HIT = 1'b0;
    step();
    chk("idle_hits.score", 32'(SCORE), 0);
    chk("idle_hits.state", 32'(STATE), 32'(ST_IDLE));

    // Illegal state encoding recovers to IDLE
    bad_state = 3'd6;
    force dut.state = state_t'(bad_state);
    #2;
    release dut.state;
    step();
    chk("illegal_state.recover", 32'(STATE), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
